// File: rtl/alu_mc.sv
// alu_mc: multi-cycle Hack-style ALU with valid/ready handshake.
//   Hack mode (00) completes in one cycle; unsigned shift-add multiply (01),
//   logical shift left (10) and arithmetic shift right (11) iterate one step
//   per cycle. Result and flags are registered and only change on completion.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_ready = idle)
//   x, y                operands; zx,nx,zy,ny,f,no Hack control bits
//   mode                00 hack, 01 mul, 10 shl, 11 sra
//   out_valid/out_ready result handshake
//   out, zr, ng, cy, ov registered result and flags
module alu_mc #(
  parameter int WordSize = 16,
  parameter int ShW      = $clog2(WordSize)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WordSize-1:0] x,
  input  logic [WordSize-1:0] y,
  input  logic                zx,
  input  logic                nx,
  input  logic                zy,
  input  logic                ny,
  input  logic                f,
  input  logic                no,
  input  logic [1:0]          mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WordSize-1:0] out,
  output logic                zr,
  output logic                ng,
  output logic                cy,
  output logic                ov
);
  localparam int W  = WordSize;
  localparam int CW = $clog2(WordSize + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]     mode_q;
  logic           no_q;
  logic [2*W-1:0] acc, mc;   // product accumulator, shifting multiplicand
  logic [W-1:0]   mp, sh;    // shifting multiplier, shift working value
  logic [CW-1:0]  cnt;       // remaining CALC steps

  // operand preprocessing on the live inputs, used only at capture
  logic [W-1:0]   zx_x, zy_y, bx, by;
  logic [W:0]     r;
  logic           hack_cy, hack_ov;
  logic [ShW-1:0] shamt;

  always_comb begin
    zx_x    = zx ? '0 : x;
    zy_y    = zy ? '0 : y;
    bx      = nx ? ~zx_x : zx_x;
    by      = ny ? ~zy_y : zy_y;
    r       = f ? ({1'b0, bx} + {1'b0, by}) : {1'b0, bx & by};
    hack_cy = f & r[W];
    // signed overflow: equal operand signs, differing sum sign (before no)
    hack_ov = f & (bx[W-1] == by[W-1]) & (r[W-1] != bx[W-1]);
    shamt   = by[ShW-1:0];
  end

  // one iteration step of the running operation
  logic [2*W-1:0] acc_nx;
  logic [W-1:0]   sh_nx;
  logic           sh_out, last;

  always_comb begin
    acc_nx = acc + (mp[0] ? mc : '0);
    if (mode_q == 2'b10) begin
      sh_nx  = {sh[W-2:0], 1'b0};
      sh_out = sh[W-1];
    end else begin
      sh_nx  = {sh[W-1], sh[W-1:1]};
      sh_out = sh[0];
    end
    last = (cnt == CW'(1));
  end

  // next state and the result to register on completion
  logic         load, res_cy, res_ov;
  logic [W-1:0] res;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    res      = '0;
    res_cy   = 1'b0;
    res_ov   = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        if (mode == 2'b00) begin
          state_nx = DONE;
          load     = 1'b1;
          res      = no ? ~r[W-1:0] : r[W-1:0];
          res_cy   = hack_cy;
          res_ov   = hack_ov;
        end else if (mode != 2'b01 && shamt == '0) begin
          state_nx = DONE;
          load     = 1'b1;
          res      = no ? ~bx : bx;
        end else begin
          state_nx = CALC;
        end
      end
      CALC: if (last) begin
        state_nx = DONE;
        load     = 1'b1;
        if (mode_q == 2'b01) begin
          res    = no_q ? ~acc_nx[W-1:0] : acc_nx[W-1:0];
          res_ov = |acc_nx[2*W-1:W];
        end else begin
          res    = no_q ? ~sh_nx : sh_nx;
          res_cy = sh_out;
        end
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      no_q   <= 1'b0;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      sh     <= '0;
      cnt    <= '0;
      out    <= '0;
      zr     <= 1'b0;
      ng     <= 1'b0;
      cy     <= 1'b0;
      ov     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        mode_q <= mode;
        no_q   <= no;
        acc    <= '0;
        mc     <= {{W{1'b0}}, bx};
        mp     <= by;
        sh     <= bx;
        cnt    <= (mode == 2'b01) ? CW'(W) : CW'(shamt);
      end else if (state == CALC) begin
        acc <= acc_nx;
        mc  <= mc << 1;
        mp  <= mp >> 1;
        sh  <= sh_nx;
        cnt <= cnt - CW'(1);
      end
      if (load) begin
        out <= res;
        zr  <= (res == '0);
        ng  <= res[W-1];
        cy  <= res_cy;
        ov  <= res_ov;
      end
    end
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, parametrised successor to the CPU's combinational Hack-style ALU. It adds a valid/ready handshake, registered result and flags, carry and overflow flags, and three iterative modes:
- shift-add multiply
- logical shift left
- arithmetic shift right
It sits between the decode stage and the register write-back path. The datapath stalls on `in_ready`/`out_valid`.

Parameters:
- WordSize, 16, datapath width in bits (≥4).
- ShW, $clog2(WordSize), width of the shift-amount field taken from the preprocessed y.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept an operation
- x  input  WordSize  operand x
- y  input  WordSize  operand y
- zx, nx, zy, ny, f, no  input  1 each  Hack control bits
- mode  input  2  00 hack, 01 mul, 10 shl, 11 sra
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result
- out  output  WordSize  registered result
- zr  output  1  out == 0
- ng  output  1  out[WordSize-1]
- cy  output  1  carry/shifted-out bit
- ov  output  1  signed add overflow / multiply overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE; out, zr, ng, cy, ov, out_valid = 0; in_ready = 1; internal counter and accumulators cleared. Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, CALC, DONE. `in_ready` = (state == IDLE). Inputs are captured on the edge where in_valid && in_ready.
- Preprocessing at capture:
  - bx = nx ? ~(zx ? 0 : x) : (zx ? 0 : x)
  - by is formed from y, zy and ny in the same way.
  - no and mode are latched.
- mode 00 (hack):
  - r = f ? bx+by : bx&by, computed WordSize+1 wide; out = no ? ~r : r.
  - f=1: cy = carry out of bit WordSize-1; ov = signed overflow of bx+by, evaluated before no.
  - f=0: cy = ov = 0.
  - Transition: IDLE→DONE directly; out_valid rises in the cycle after capture (latency 1).
- mode 01 (mul): unsigned shift-add.
  - One multiplier bit of by per cycle, LSB first, over a 2*WordSize accumulator.
  - CALC lasts exactly WordSize cycles, then DONE. out_valid is high WordSize+1 cycles after capture.
  - out = no ? ~low : low, where low is the low half of the product.
  - ov = |high half; cy = 0.
- mode 10 (shl) / 11 (sra):
  - Amount n = by[ShW-1:0]; one bit position per cycle in CALC.
  - shl shifts in 0. sra replicates the MSB.
  - cy = last bit shifted out; ov = 0; no is applied to the final value.
  - n=0: IDLE→DONE directly (latency 1), cy = 0, out = bx (or ~bx if no=1).
  - Otherwise latency is n+1.
- Flags: zr and ng are derived from the final out and registered together with out. They are never updated while CALC is in progress; out and the flags hold their previous values until DONE.
- DONE:
  - out_valid = 1; out and all flags stable while out_ready = 0 (backpressure, unbounded).
  - On out_valid && out_ready: next state IDLE, out_valid = 0. out and flags keep their values.
  - A new capture is possible at the earliest one cycle after the handshake (no same-cycle turnaround).
- in_valid while busy is ignored (in_ready = 0). x/y changing after capture has no effect.
- Arithmetic wraps modulo 2^WordSize. There are no X outputs after reset.

Test Plan:
1. mode 00, f=1, other controls 0, x=0x7FFF, y=0x0001 → one cycle after capture: out=0x8000, ng=1, ov=1, cy=0, zr=0.
2. mode 00 add, x=0xFFFF, y=0x0001 → out=0x0000, zr=1, cy=1, ov=0. Then zx=1, nx=1, zy=1, f=1, no=1 (computes -1 → ~(0xFFFF+0)) → out=0x0000, zr=1.
3. mode 01, x=300, y=300 → out_valid exactly 17 cycles after capture, out=0x5F90, ov=1; in_ready=0 throughout CALC. Also x=0x00FF, y=0x0002 → out=0x01FE, ov=0.
4. mode 10, x=0x8001, y=1 → out=0x0002, cy=1, latency 2. mode 11, x=0x8000, y=15 → out=0xFFFF, ng=1, latency 16. mode 11, y=0 → out=x, latency 1.
5. Backpressure: complete a mul with out_ready=0 for 5 cycles → out, flags and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready → next cycle out_valid=0, in_ready=1.
6. Reset mid-mul: assert rst_n=0 asynchronously at CALC cycle 8 → immediately out=0, flags=0, out_valid=0, in_ready=1. A following mode-00 op completes normally.
